// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then start bit, 8 data bits LSB first, odd parity, stop.
// Define PS2_TX_ACK_CHECK_EN to add the ACK state and drive o_ack_err; otherwise o_ack_err is tied 0.
module ps2_tx #(
  parameter int unsigned RTS_CYCLES     = 10000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_wr_ps2,
  input  logic [7:0] i_din,
  inout  wire        io_ps2c,
  inout  wire        io_ps2d,
  output logic       o_tx_idle,
  output logic       o_tx_done_tick,
  output logic       o_time_out,
  output logic       o_ack_err
);

  localparam int unsigned CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PKT_W   = 9;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP
`ifdef PS2_TX_ACK_CHECK_EN
    , S_ACK
`endif
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [PKT_W-1:0]   pkt_q, pkt_n;
  logic [BIT_W-1:0]   bit_q, bit_n;
  logic               done_c, time_out_c;
  logic               c_low_n, d_low_n, idle_n;
  logic               c_low_q, d_low_q, idle_q, done_q, time_out_q;

  logic [1:0]            c_sync_q;
  logic [FILTER_LEN-1:0] filt_reg_q;
  logic                  filt_q;
  logic                  fall_edge;

  // Open-drain drivers: only ever pull low or release
  assign io_ps2c = c_low_q ? 1'b0 : 1'bz;
  assign io_ps2d = d_low_q ? 1'b0 : 1'bz;

  // Clock synchroniser and glitch filter with hysteresis
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      c_sync_q   <= 2'b11;
      filt_reg_q <= '1;
      filt_q     <= 1'b1;
    end else begin
      c_sync_q   <= {c_sync_q[0], io_ps2c};
      filt_reg_q <= {filt_reg_q[FILTER_LEN-2:0], c_sync_q[1]};
      if (&filt_reg_q) begin
        filt_q <= 1'b1;
      end else if (filt_reg_q == '0) begin
        filt_q <= 1'b0;
      end
    end
  end

  assign fall_edge = filt_q && (filt_reg_q == '0);

`ifdef PS2_TX_ACK_CHECK_EN
  logic [1:0] d_sync_q;
  logic       ack_err_c, ack_err_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      d_sync_q  <= 2'b11;
      ack_err_q <= 1'b0;
    end else begin
      d_sync_q  <= {d_sync_q[0], io_ps2d};
      ack_err_q <= ack_err_c;
    end
  end

  assign o_ack_err = ack_err_q;
`else
  assign o_ack_err = 1'b0;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pkt_q      <= '0;
      bit_q      <= '0;
      c_low_q    <= 1'b0;
      d_low_q    <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      pkt_q      <= pkt_n;
      bit_q      <= bit_n;
      c_low_q    <= c_low_n;
      d_low_q    <= d_low_n;
      idle_q     <= idle_n;
      done_q     <= done_c;
      time_out_q <= time_out_c;
    end
  end

  // Next-state logic; a device edge always takes priority over the timeout
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    pkt_n      = pkt_q;
    bit_n      = bit_q;
    done_c     = 1'b0;
    time_out_c = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_err_c  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_wr_ps2) begin
          pkt_n   = {~^i_din, i_din};
          cnt_n   = '0;
          state_n = S_RTS;
        end
      end
      S_RTS: begin
        if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_START;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (fall_edge) begin
          cnt_n = '0;
          if (state_q == S_START) begin
            bit_n   = BIT_W'(8);
            state_n = S_DATA;
          end else if (state_q == S_DATA) begin
            if (bit_q != '0) begin
              pkt_n = {1'b0, pkt_q[PKT_W-1:1]};
              bit_n = bit_q - BIT_W'(1);
            end else begin
              state_n = S_STOP;
            end
          end else if (state_q == S_STOP) begin
`ifdef PS2_TX_ACK_CHECK_EN
            state_n = S_ACK;
`else
            done_c  = 1'b1;
            state_n = S_IDLE;
`endif
`ifdef PS2_TX_ACK_CHECK_EN
          end else if (state_q == S_ACK) begin
            if (!d_sync_q[1]) begin
              done_c = 1'b1;
            end else begin
              ack_err_c = 1'b1;
            end
            state_n = S_IDLE;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_n      = '0;
          time_out_c = 1'b1;
          state_n    = S_IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Line drive and idle flag follow the state being entered, so they register alongside it
  always_comb begin
    c_low_n = 1'b0;
    d_low_n = 1'b0;
    idle_n  = 1'b0;
    c_low_n = (state_n == S_RTS);
    d_low_n = (state_n == S_START) || ((state_n == S_DATA) && !pkt_n[0]);
    idle_n  = (state_n == S_IDLE);
  end

  assign o_tx_idle      = idle_q;
  assign o_tx_done_tick = done_q;
  assign o_time_out     = time_out_q;

endmodule
